// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC-3 memory-cycle sequencer: FSM state encoding, response codes, region defaults.
// Latency: none (types and constants only).
// Backpressure: n/a.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ASSERT = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_RESP   = 3'd5
    } seq_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ACV     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Default LC-3 map: user space starts at x3000, device registers at xFE00 and up.
    localparam logic [15:0] DEF_USER_LO = 16'h3000;
    localparam logic [15:0] DEF_IO_BASE = 16'hFE00;

endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// Request/response handshake plus memory/IO bus between control FSM, sequencer and memory.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side, r on the bus.
// Modports: slave = the sequencer; master = its environment (control FSM on req/rsp, memory on mio_en/r).
interface lc3_mem_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_user;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              mio_en;
    logic              rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              r;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_user, req_addr, req_wdata,
        output mem_rdata, r, rsp_ready,
        input  req_ready, mio_en, rw, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_user, req_addr, req_wdata,
        input  mem_rdata, r, rsp_ready,
        output req_ready, mio_en, rw, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/lc3_acv_check.sv
// Access-control-violation check: user mode may only touch [USER_LO, IO_BASE).
// Latency: combinational.
// Backpressure: none.
// Ports: user (requester in user mode), addr (access address), acv (1 = access denied).
module lc3_acv_check #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] USER_LO = ADDR_W'(16'h3000),
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(16'hFE00)
) (
    input  logic              user,
    input  logic [ADDR_W-1:0] addr,
    output logic              acv
);

    assign acv = user & ((addr < USER_LO) | (addr >= IO_BASE));

endmodule

// File: rtl/lc3_mem_sequencer.sv
// LC-3 memory-cycle sequencer: ACV check, mio_en/rw drive until r, timeout with bounded retry, data+status return.
// Latency: accept -> rsp_valid in 4 cycles minimum (CHECK, ASSERT, WAIT with r); ACV errors in 2.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready, next request one cycle later.
// Ports: i_Clk, reset (sync, active high), bus (slave modport: req_*, mio_en/rw/mem_*/r, rsp_*, busy).
module lc3_mem_sequencer
    import lc3_mem_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] USER_LO   = ADDR_W'(DEF_USER_LO),
    parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(DEF_IO_BASE),
    parameter int                TIMEOUT   = 255,
    parameter int                MAX_RETRY = 2
) (
    input  logic                i_Clk,
    input  logic                reset,
    lc3_mem_sequencer_if.slave  bus
);

    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [CNT_W:0]     TMO_LAST_V  = (CNT_W+1)'(TMO_LAST);
    localparam logic [RETRY_W-1:0] RETRY_MAX_V = RETRY_W'(MAX_RETRY);

    seq_state_e state, state_nxt;

    logic              wr_q;
    logic              user_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [1:0]        rsp_err_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    logic acv;
    logic timeout_hit;
    logic retry_left;

    lc3_acv_check #(
        .ADDR_W  (ADDR_W),
        .USER_LO (USER_LO),
        .IO_BASE (IO_BASE)
    ) u_acv (
        .user (user_q),
        .addr (mem_addr_q),
        .acv  (acv)
    );

    // ASSERT counts as the first bus cycle of a burst, so the WAIT that
    // would bring the counter to TIMEOUT-1 is the last one of the burst.
    assign timeout_hit = (TIMEOUT != 0) && (({1'b0, tmo_cnt} + (CNT_W+1)'(1)) >= TMO_LAST_V);
    assign retry_left  = (retry_cnt < RETRY_MAX_V);

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.mio_en    = 1'b0;
        bus.rw        = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ST_CHECK;
            end
            ST_CHECK:  state_nxt = acv ? ST_RESP : ST_ASSERT;
            ST_ASSERT: begin
                // r is ignored here: the bus needs one setup cycle.
                bus.mio_en = 1'b1;
                bus.rw     = wr_q;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                bus.mio_en = 1'b1;
                bus.rw     = wr_q;
                // r wins over a timeout hit in the same cycle.
                if (bus.r)            state_nxt = ST_RESP;
                else if (timeout_hit) state_nxt = ST_GAP;
            end
            ST_GAP:  state_nxt = retry_left ? ST_ASSERT : ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            wr_q        <= 1'b0;
            user_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q        <= bus.req_write;
                        user_q      <= bus.req_user;
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= bus.req_wdata;
                    end
                end
                ST_CHECK: begin
                    if (acv) begin
                        rsp_err_q   <= ERR_ACV;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_ASSERT: tmo_cnt <= '0;
                ST_WAIT: begin
                    if (bus.r) begin
                        rsp_err_q   <= ERR_OK;
                        rsp_rdata_q <= wr_q ? '0 : bus.mem_rdata;
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (retry_left) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end else begin
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) retry_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/lc3_mem_sequencer.md
Name: lc3_mem_sequencer

Overview:
Parametrised memory-cycle sequencer that replaces the per-state "MDR <- M[MAR]" and "M[MAR] <- MDR" wait loops in the LC-3 control FSM with one reusable unit.
- Accepts a read/write request from the control FSM.
- Performs the access-control-violation (ACV) check.
- Drives mio_en/rw until memory raises r, with timeout and bounded retry.
- Returns data and a status code.
- Sits between the control FSM and the memory/IO bus; generalised in address/data width, privilege region bounds and timeout policy.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- USER_LO, 16'h3000, lowest address user mode may touch.
- IO_BASE, 16'hFE00, first address of the privileged IO/device region (inclusive).
- TIMEOUT, 255, WAIT cycles without r before abort; 0 disables timeout.
- MAX_RETRY, 2, re-issues allowed after a timeout before an error is reported.

Ports:
- i_Clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_user  in  1  requester in user mode (PSR[15]).
- req_addr  in  ADDR_W  access address (MAR).
- req_wdata  in  DATA_W  write data (MDR).
- mio_en  out  1  memory enable.
- rw  out  1  1 = write.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data, valid with r.
- r  in  1  memory ready.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  captured read data (0 on writes and errors).
- rsp_err  out  2  00 OK, 01 ACV, 10 TIMEOUT.
- busy  out  1  not in IDLE.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of i_Clk.
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - Retry and timeout counters cleared.
  - Reset mid-access drops mio_en on the next edge; any pending response is discarded.
- States: IDLE, CHECK, ASSERT, WAIT, GAP, RESP.
- IDLE: on req_valid & req_ready, latch write, user, addr, wdata (mem_addr/mem_wdata update on this edge); go to CHECK.
- CHECK (1 cycle):
  - ACV = req_user & (addr < USER_LO | addr >= IO_BASE).
  - ACV true -> RESP with err = 01; mio_en is never asserted.
  - Otherwise -> ASSERT.
- ASSERT (1 cycle): mio_en = 1, rw = latched write; timeout counter cleared. r is ignored in this state; the bus needs one setup cycle.
- WAIT: mio_en/rw held; mem_addr/mem_wdata stable.
  - r = 1 -> RESP with err = 00. On a read, rsp_rdata <= mem_rdata on the same edge.
  - Otherwise the counter increments.
  - If TIMEOUT != 0 and counter reaches TIMEOUT-1 with r = 0 -> GAP.
- GAP (1 cycle): mio_en = 0.
  - retry < MAX_RETRY -> retry++, go to ASSERT.
  - Otherwise -> RESP with err = 10.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err held stable until rsp_ready. On rsp_valid & rsp_ready -> IDLE, retry cleared.
  - Back-to-back: req_ready rises in the cycle after the handshake; no same-cycle accept.
- Minimum read latency: accept at cycle 0, CHECK 1, ASSERT 2, WAIT 3 (r = 1), rsp_valid at cycle 4.
- r arriving in the same cycle the timeout is hit: r wins, normal completion.
- Counter width: clog2(TIMEOUT+1); no wrap is possible because it saturates into GAP.
- busy = (state != IDLE).

Decomposition:
- Package lc3_mem_pkg:
  - state enum encoding.
  - rsp_err codes (ERR_OK, ERR_ACV, ERR_TIMEOUT).
  - default USER_LO / IO_BASE constants.
- Sub-module lc3_acv_check: combinational, parametrised ADDR_W/USER_LO/IO_BASE; inputs user and addr, output acv. Reused later by the interrupt/RTI path.

Test Plan:
- Supervisor read of 16'h3000, memory raises r 3 cycles after mio_en with rdata 16'hBEEF -> mio_en high for exactly 4 cycles, rw = 0; rsp_valid with rsp_rdata = 16'hBEEF, err = 00.
- User read of 16'h2FFF, then user write of 16'hFE00 -> mio_en never asserts; each gives rsp_err = 01, rsp_rdata = 0. User read of 16'h3000 completes with err = 00.
- Supervisor write to 16'h4000, wdata 16'h1234, r never asserted, TIMEOUT = 4, MAX_RETRY = 2 -> three 4-cycle mio_en bursts, each followed by a 1-cycle GAP with mio_en = 0; then rsp_err = 10.
- Timeout with r on the retry: r held low for the first burst, r = 1 in the second burst's WAIT -> err = 00 with correct data; retry count cleared for the next request.
- rsp_ready held low for 5 cycles after completion -> rsp_valid, rsp_rdata and rsp_err stable throughout; req_ready = 0 until the cycle after rsp_ready.
- reset pulsed in WAIT with mio_en high -> next cycle mio_en = 0, rsp_valid = 0, req_ready = 1; a subsequent read completes normally.
